// File: rtl/seven_segment_monitor.sv
// seven_segment_monitor
// Receive end of the multiplexed four-digit seven-segment display interface.
// Samples the active-low anode/segment lines, waits until a pattern has been
// stable long enough to rule out glitches and mid-transition states, then
// decodes it into a hex nibble, decimal point and validity for that digit.
// Each digit has a refresh timer that drops its valid flag when the
// controller stops refreshing it (for example, a digit it has blanked).
// Also flags sticky protocol errors and pulses once per complete frame.

module seven_segment_monitor #(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT_BITS  = 19
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  anode_in,
   input  logic [7:0]  segment_in,
   input  logic        clear_errors,
   output logic [15:0] data_out,
   output logic [3:0]  digit_valid,
   output logic [3:0]  digit_point,
   output logic        frame_done,
   output logic        anode_error,
   output logic        seg_error
);

   // One extra count value lets the counter park at STABLE_CYCLES after the
   // commit, so a long stable period commits only once.
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PARK   = CNT_W'(STABLE_CYCLES);
   localparam logic [TIMEOUT_BITS-1:0] TMR_MAX = '1;
   localparam logic [11:0] BLANK = 12'hFFF;

   logic [11:0]             cur_q, last_q;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [15:0]             data_q, data_d;
   logic [3:0]              valid_q, valid_d;
   logic [3:0]              point_q, point_d;
   logic [3:0]              seen_q, seen_d;
   logic                    frame_q, frame_d;
   logic                    aerr_q, aerr_d;
   logic                    serr_q, serr_d;
   logic [TIMEOUT_BITS-1:0] timer_q [4];
   logic [TIMEOUT_BITS-1:0] timer_d [4];

   logic       commit;
   logic       dig_commit;
   logic [3:0] an_low;
   logic [2:0] low_count;
   logic [3:0] seen_next;
   logic [4:0] dec;

   // Segment code to {hit, nibble}; anything not in the table is a miss.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      logic [4:0] r;
      r = 5'h00;
      case (seg)
         7'h40: r = {1'b1, 4'h0};
         7'h79: r = {1'b1, 4'h1};
         7'h24: r = {1'b1, 4'h2};
         7'h30: r = {1'b1, 4'h3};
         7'h19: r = {1'b1, 4'h4};
         7'h12: r = {1'b1, 4'h5};
         7'h02: r = {1'b1, 4'h6};
         7'h78: r = {1'b1, 4'h7};
         7'h00: r = {1'b1, 4'h8};
         7'h10: r = {1'b1, 4'h9};
         7'h08: r = {1'b1, 4'hA};
         7'h03: r = {1'b1, 4'hB};
         7'h46: r = {1'b1, 4'hC};
         7'h21: r = {1'b1, 4'hD};
         7'h06: r = {1'b1, 4'hE};
         7'h0E: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   // Next-state: stability count, commit decode, refresh timers, errors, frame.
   always_comb begin
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      point_d   = point_q;
      seen_d    = seen_q;
      frame_d   = 1'b0;
      aerr_d    = clear_errors ? 1'b0 : aerr_q;
      serr_d    = clear_errors ? 1'b0 : serr_q;
      an_low    = ~cur_q[11:8];
      low_count = 3'd0;
      seen_next = seen_q;
      dec       = decode_seg(cur_q[6:0]);

      if (cur_q != last_q) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_PARK) begin
         cnt_d = cnt_q + 1'b1;
      end

      commit = (cur_q == last_q) && (cnt_q == CNT_COMMIT);

      for (int i = 0; i < 4; i++) begin
         if (an_low[i]) begin
            low_count = low_count + 3'd1;
         end
      end
      dig_commit = commit && (low_count == 3'd1);

      // Timeout first so a same-edge commit to the digit overrides it.
      for (int i = 0; i < 4; i++) begin
         timer_d[i] = (timer_q[i] == TMR_MAX) ? timer_q[i] : timer_q[i] + 1'b1;
         if ((timer_d[i] == TMR_MAX) && (timer_q[i] != TMR_MAX)) begin
            valid_d[i] = 1'b0;
         end
         if (dig_commit && an_low[i]) begin
            timer_d[i] = '0;
            valid_d[i] = dec[4];
            if (dec[4]) begin
               data_d[4*i +: 4] = dec[3:0];
               point_d[i]       = ~cur_q[7];
            end
         end
      end

      if (dig_commit) begin
         if (!dec[4]) begin
            serr_d = 1'b1;
         end
         seen_next = seen_q | an_low;
         if (seen_next == 4'hF) begin
            frame_d = 1'b1;
            seen_d  = 4'h0;
         end else begin
            seen_d  = seen_next;
         end
      end else if (commit && (low_count > 3'd1)) begin
         aerr_d = 1'b1;
      end
   end

   // State registers with synchronous reset; cur/last reset to the blank pattern.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_q   <= BLANK;
         last_q  <= BLANK;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= '0;
         point_q <= '0;
         seen_q  <= '0;
         frame_q <= 1'b0;
         aerr_q  <= 1'b0;
         serr_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            timer_q[i] <= '0;
         end
      end else begin
         cur_q   <= {anode_in, segment_in};
         last_q  <= cur_q;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         point_q <= point_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         aerr_q  <= aerr_d;
         serr_q  <= serr_d;
         for (int i = 0; i < 4; i++) begin
            timer_q[i] <= timer_d[i];
         end
      end
   end

   assign data_out    = data_q;
   assign digit_valid = valid_q;
   assign digit_point = point_q;
   assign frame_done  = frame_q;
   assign anode_error = aerr_q;
   assign seg_error   = serr_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Testbench for seven_segment_monitor. A behavioural reference model tracks
// the sampled input history and applies the display rules directly: a pattern
// commits on the edge after it has been seen on STABLE+1 consecutive edges,
// and a digit is valid while its last refresh is under the timeout age.

module tb_seven_segment_monitor;

   localparam int S    = 4;
   localparam int TB_T = 6;
   localparam int TMAX = (1 << TB_T) - 1;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  anode_in;
   logic [7:0]  segment_in;
   logic        clear_errors;
   logic [15:0] data_out;
   logic [3:0]  digit_valid;
   logic [3:0]  digit_point;
   logic        frame_done;
   logic        anode_error;
   logic        seg_error;

   seven_segment_monitor #(
      .STABLE_CYCLES(S),
      .TIMEOUT_BITS (TB_T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .anode_in    (anode_in),
      .segment_in  (segment_in),
      .clear_errors(clear_errors),
      .data_out    (data_out),
      .digit_valid (digit_valid),
      .digit_point (digit_point),
      .frame_done  (frame_done),
      .anode_error (anode_error),
      .seg_error   (seg_error)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [6:0]  codes [16];
   logic [12:0] hist [0:S+1];
   int          k;
   logic [3:0]  m_nib [4];
   bit          m_ok  [4];
   bit          m_pt  [4];
   int          m_last[4];
   logic [3:0]  m_seen;
   bit          m_frame, m_aerr, m_serr;

   function automatic logic [15:0] m_data();
      return {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
   endfunction

   function automatic logic [3:0] m_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_ok[i] && ((k - m_last[i]) < TMAX);
      return v;
   endfunction

   function automatic logic [3:0] m_point();
      return {m_pt[3], m_pt[2], m_pt[1], m_pt[0]};
   endfunction

   function automatic logic [26:0] m_vec();
      return {m_data(), m_valid(), m_point(), m_frame, m_aerr, m_serr};
   endfunction

   function automatic logic [26:0] dut_vec();
      return {data_out, digit_valid, digit_point, frame_done, anode_error, seg_error};
   endfunction

   // Apply the rules for one clock edge using the inputs currently driven.
   task automatic model_edge();
      logic [12:0] smp;
      logic [3:0]  low;
      bit          commit;
      int          dig, code;
      k++;
      smp = reset ? 13'h1000 : {1'b0, anode_in, segment_in};
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            m_nib[i] = 4'h0; m_ok[i] = 0; m_pt[i] = 0; m_last[i] = k;
         end
         m_seen = 4'h0; m_frame = 0; m_aerr = 0; m_serr = 0;
      end else begin
         commit = !hist[0][12];
         for (int i = 1; i <= S; i++) if (hist[i] != hist[0]) commit = 0;
         if (hist[S+1] == hist[0]) commit = 0;
         m_frame = 0;
         if (clear_errors) begin m_aerr = 0; m_serr = 0; end
         if (commit) begin
            low = ~hist[0][11:8];
            if ($countones(low) >= 2) begin
               m_aerr = 1;
            end else if ($countones(low) == 1) begin
               dig = 0;
               for (int i = 0; i < 4; i++) if (low[i]) dig = i;
               code = -1;
               for (int v = 0; v < 16; v++) if (codes[v] == hist[0][6:0]) code = v;
               if (code >= 0) begin
                  m_nib[dig] = 4'(code); m_ok[dig] = 1; m_pt[dig] = ~hist[0][7];
               end else begin
                  m_ok[dig] = 0; m_serr = 1;
               end
               m_last[dig] = k;
               m_seen[dig] = 1'b1;
               if (m_seen == 4'hF) begin m_frame = 1; m_seen = 4'h0; end
            end
         end
      end
      for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = smp;
   endtask

   // One clock: drive at negedge, model the posedge, return at next negedge.
   task automatic cyc(input logic [3:0] a, input logic [7:0] s, input logic c, input logic r);
      anode_in = a; segment_in = s; clear_errors = c; reset = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
      for (int i = 0; i < n; i++) cyc(a, s, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      int pulses = 0;
      for (int i = 0; i < 3; i++) cyc(4'hF, 8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < 50; i++) begin
         cyc(4'hF, 8'hFF, 1'b0, 1'b0);
         if (frame_done) pulses++;
         n_total++;
         if (dut_vec() !== 27'h0) $display("FAIL reset_outputs: got %h expected 0", dut_vec());
         else n_pass++;
      end
      n_total++;
      if (pulses != 0) $display("FAIL reset_frame: got %0d pulses expected 0", pulses);
      else n_pass++;
   endtask

   task automatic test_single_digit();
      logic [8:0] exp;
      for (int n = 1; n <= 10; n++) begin
         cyc(4'b1110, 8'h92, 1'b0, 1'b0);
         exp = (n >= 6) ? {4'h5, 4'b0001, 1'b0} : 9'h0;
         n_total++;
         if ({data_out[3:0], digit_valid, digit_point[0]} !== exp)
            $display("FAIL single_digit n=%0d: got %h expected %h", n,
                     {data_out[3:0], digit_valid, digit_point[0]}, exp);
         else n_pass++;
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL single_model n=%0d: got %h expected %h", n, dut_vec(), m_vec());
         else n_pass++;
      end
   endtask

   task automatic test_scan();
      logic [3:0] an  [4];
      logic [7:0] sg  [4];
      int pulses = 0, at_d = -1, at_c = -1;
      an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      sg = '{8'hF9, 8'h8E, 8'h30, 8'h88};
      for (int d = 0; d < 4; d++) begin
         for (int c = 1; c <= 16; c++) begin
            cyc(an[d], sg[d], 1'b0, 1'b0);
            if (frame_done) begin pulses++; at_d = d; at_c = c; end
         end
      end
      n_total++;
      if (pulses != 1 || at_d != 3 || at_c != 6)
         $display("FAIL scan_frame: got pulses=%0d digit=%0d cycle=%0d expected 1/3/6", pulses, at_d, at_c);
      else n_pass++;
      n_total++;
      if (data_out !== 16'hA3F1) $display("FAIL scan_data: got %h expected a3f1", data_out);
      else n_pass++;
      n_total++;
      if (digit_point !== 4'b0100) $display("FAIL scan_point: got %b expected 0100", digit_point);
      else n_pass++;
      n_total++;
      if (digit_valid !== 4'hF) $display("FAIL scan_valid: got %b expected 1111", digit_valid);
      else n_pass++;
   endtask

   task automatic test_glitch();
      logic [15:0] d0;
      logic [3:0]  p0;
      d0 = data_out; p0 = digit_point;
      for (int i = 0; i < 13; i++) begin
         if (i < 3) cyc(4'b1101, 8'hA4, 1'b0, 1'b0);
         else       cyc(4'hF, 8'hFF, 1'b0, 1'b0);
         n_total++;
         if (data_out !== d0 || digit_point !== p0 || frame_done !== 1'b0)
            $display("FAIL glitch_hold i=%0d: got %h/%b/%b expected %h/%b/0", i, data_out, digit_point, frame_done, d0, p0);
         else n_pass++;
         n_total++;
         if (dut_vec() !== m_vec()) $display("FAIL glitch_model i=%0d: got %h expected %h", i, dut_vec(), m_vec());
         else n_pass++;
      end
   endtask

   task automatic test_errors();
      logic [15:0] d0;
      d0 = data_out;
      hold(4'b1100, 8'h92, 10);
      n_total++;
      if (anode_error !== 1'b1 || data_out !== d0)
         $display("FAIL anode_err: got err=%b data=%h expected 1/%h", anode_error, data_out, d0);
      else n_pass++;
      hold(4'hF, 8'hFF, 2);
      hold(4'b1101, 8'hFF, 10);
      n_total++;
      if (digit_valid[1] !== 1'b0 || seg_error !== 1'b1)
         $display("FAIL seg_err: got valid1=%b err=%b expected 0/1", digit_valid[1], seg_error);
      else n_pass++;
      cyc(4'hF, 8'hFF, 1'b1, 1'b0);
      n_total++;
      if ({anode_error, seg_error} !== 2'b00)
         $display("FAIL clear_errors: got %b expected 00", {anode_error, seg_error});
      else n_pass++;
      // Set anode_error, then a bad segment commit coincides with clear.
      hold(4'b0011, 8'hC0, 10);
      hold(4'hF, 8'hFF, 2);
      hold(4'b1011, 8'h7F, 5);
      cyc(4'b1011, 8'h7F, 1'b1, 1'b0);
      n_total++;
      if ({anode_error, seg_error} !== 2'b01)
         $display("FAIL clear_vs_seg: got %b expected 01", {anode_error, seg_error});
      else n_pass++;
      hold(4'hF, 8'hFF, 2);
      hold(4'b1001, 8'hC0, 5);
      cyc(4'b1001, 8'hC0, 1'b1, 1'b0);
      n_total++;
      if ({anode_error, seg_error} !== 2'b10)
         $display("FAIL clear_vs_anode: got %b expected 10", {anode_error, seg_error});
      else n_pass++;
      n_total++;
      if (dut_vec() !== m_vec()) $display("FAIL errors_model: got %h expected %h", dut_vec(), m_vec());
      else n_pass++;
   endtask

   task automatic test_timeout();
      int fall_at = -1;
      cyc(4'hF, 8'hFF, 1'b0, 1'b1);
      cyc(4'hF, 8'hFF, 1'b0, 1'b1);
      hold(4'b1110, 8'h99, 6);
      n_total++;
      if (digit_valid[0] !== 1'b1 || data_out[3:0] !== 4'h4)
         $display("FAIL timeout_commit: got valid0=%b nib=%h expected 1/4", digit_valid[0], data_out[3:0]);
      else n_pass++;
      for (int j = 1; j <= 200 && fall_at < 0; j++) begin
         cyc(4'hF, 8'hFF, 1'b0, 1'b0);
         if (digit_valid[0] === 1'b0) fall_at = j;
      end
      n_total++;
      if (fall_at != TMAX) $display("FAIL timeout_cycles: got %0d expected %0d", fall_at, TMAX);
      else n_pass++;
      n_total++;
      if (data_out[3:0] !== 4'h4) $display("FAIL timeout_data: got %h expected 4", data_out[3:0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      hold(4'b1110, 8'hC0, 8);
      hold(4'b1101, 8'hF9, 8);
      hold(4'b1011, 8'hA4, 3);
      cyc(4'b1011, 8'hA4, 1'b0, 1'b1);
      n_total++;
      if (dut_vec() !== 27'h0) $display("FAIL reset_mid: got %h expected 0", dut_vec());
      else n_pass++;
      for (int j = 1; j <= 8; j++) begin
         cyc(4'b1011, 8'hA4, 1'b0, 1'b0);
         n_total++;
         if (digit_valid !== ((j >= 6) ? 4'b0100 : 4'b0000) ||
             data_out !== ((j >= 6) ? 16'h0200 : 16'h0000))
            $display("FAIL after_reset j=%0d: got %b/%h", j, digit_valid, data_out);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [3:0] a;
      logic [7:0] s;
      int         hn;
      cyc(4'hF, 8'hFF, 1'b0, 1'b1);
      for (int sgi = 0; sgi < 60; sgi++) begin
         case ($urandom_range(0, 9))
            0:       a = 4'hF;
            1, 2:    a = 4'($urandom);
            default: a = ~(4'b0001 << $urandom_range(0, 3));
         endcase
         if ($urandom_range(0, 4) == 0) s = 8'($urandom);
         else s = {1'($urandom), codes[$urandom_range(0, 15)]};
         hn = $urandom_range(1, 12);
         for (int j = 0; j < hn; j++) begin
            cyc(a, s, ($urandom_range(0, 15) == 0), 1'b0);
            n_total++;
            if (dut_vec() !== m_vec())
               $display("FAIL rand_cycle k=%0d: got %h expected %h", k, dut_vec(), m_vec());
            else n_pass++;
         end
      end
   endtask

   initial begin
      codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      for (int i = 0; i <= S + 1; i++) hist[i] = 13'h1000;
      k = 0;
      for (int i = 0; i < 4; i++) begin
         m_nib[i] = 4'h0; m_ok[i] = 0; m_pt[i] = 0; m_last[i] = 0;
      end
      m_seen = 4'h0; m_frame = 0; m_aerr = 0; m_serr = 0;
      reset = 1'b1; anode_in = 4'hF; segment_in = 8'hFF; clear_errors = 1'b0;

      test_reset();
      test_single_digit();
      test_scan();
      test_glitch();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_random();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
